// File: rtl/power_spectrum.sv
// power_spectrum: squares FFT bin magnitudes into a Q15 periodogram stream
// buffered by a show-ahead FIFO with credit-based input back-pressure.
module power_spectrum #(
  parameter int IN_W       = 16,
  parameter int Q          = 15,
  parameter int FFT_SIZE   = 512,
  parameter int NUM_BINS   = 257,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] fft_re,
  input  logic signed [IN_W-1:0] fft_im,
  input  logic                   fft_valid,
  input  logic                   fft_last,
  output logic                   fft_ready,
  output logic signed [31:0]     pgram_data,
  output logic                   pgram_valid,
  output logic                   pgram_last,
  input  logic                   pgram_ready,
  output logic                   frame_err
);
  localparam int BW = $clog2(FFT_SIZE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = 2 * IN_W;
  logic [BW-1:0] bin_idx;
  logic s1_valid, s1_last, s2_valid, s2_last;
  logic [PW-1:0] rr, ii;
  logic signed [PW-1:0] re_x, im_x;
  logic [31:0] p;
  logic [32:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [AW+1:0] used;
  logic [PW:0] sum;
  logic accept, keep, pop;
  // In-flight pipeline entries hold reserved FIFO slots, so the pipeline never stalls.
  always_comb begin
    used        = (AW+2)'(count) + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);
    fft_ready   = used < (AW+2)'(FIFO_DEPTH);
    accept      = fft_valid && fft_ready;
    keep        = {1'b0, bin_idx} < (BW+1)'(NUM_BINS);
    re_x        = PW'(fft_re);
    im_x        = PW'(fft_im);
    sum         = (PW+1)'(rr) + (PW+1)'(ii);
    pgram_valid = count != '0;
    pop         = pgram_valid && pgram_ready;
    pgram_data  = pgram_valid ? mem[rd_ptr][31:0] : '0;
    pgram_last  = pgram_valid && mem[rd_ptr][32];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bin_idx   <= '0;
      frame_err <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      rr        <= '0;
      ii        <= '0;
      p         <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (accept) bin_idx <= fft_last ? '0 : bin_idx + 1'b1;
      if (accept && fft_last && bin_idx != BW'(FFT_SIZE-1)) frame_err <= 1'b1;
      s1_valid <= accept && keep;
      s1_last  <= bin_idx == BW'(NUM_BINS-1);
      rr       <= re_x * re_x;
      ii       <= im_x * im_x;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      p        <= 32'(sum >> Q);
      if (s2_valid) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(s2_valid) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (s2_valid) mem[wr_ptr] <= {s2_last, p};
endmodule

// File: tb/tb_power_spectrum.sv
// tb_power_spectrum: directed vectors with hand-computed values plus a bin-tracking scoreboard.
module tb_power_spectrum;
  logic clk = 1'b0, rst = 1'b1;
  logic signed [15:0] fft_re = '0, fft_im = '0;
  logic fft_valid = 1'b0, fft_last = 1'b0, pgram_ready = 1'b1;
  logic fft_ready, pgram_valid, pgram_last, frame_err;
  logic signed [31:0] pgram_data;
  int n_cmp = 0, n_err = 0;
  int n_out, n_acc, n_last, last_pos, tb_bin;
  logic [32:0] exp_q[$];
  longint out_q[$];
  longint bp_exp [8] = '{30, 122, 274, 488, 762, 1098, 1495, 1953};

  power_spectrum dut (
    .clk(clk), .rst(rst), .fft_re(fft_re), .fft_im(fft_im), .fft_valid(fft_valid),
    .fft_last(fft_last), .fft_ready(fft_ready), .pgram_data(pgram_data),
    .pgram_valid(pgram_valid), .pgram_last(pgram_last), .pgram_ready(pgram_ready),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [31:0] power(input logic signed [15:0] re, input logic signed [15:0] im);
    longint r = re, i = im;
    return 32'((r * r + i * i) / 32768);
  endfunction

  task automatic clear_stats();
    n_out = 0; n_acc = 0; n_last = 0; last_pos = 0;
    out_q.delete();
  endtask

  // Inputs and pgram_ready change at posedge+1, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      tb_bin = 0;
    end else begin
      if (pgram_valid && pgram_ready) begin
        n_out++;
        out_q.push_back(longint'(pgram_data));
        if (pgram_last) begin n_last++; last_pos = n_out; end
        if (exp_q.size() == 0) check("extra_output", 1, 0);
        else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("sb_data", pgram_data, e[31:0]);
          check("sb_last", pgram_last, e[32]);
        end
      end
      if (fft_valid && fft_ready) begin
        n_acc++;
        if (tb_bin < 257) exp_q.push_back({tb_bin == 256, power(fft_re, fft_im)});
        tb_bin = fft_last ? 0 : (tb_bin + 1) % 512;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    fft_valid = 1'b0; fft_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_stats();
  endtask

  task automatic beat(input logic [15:0] re, input logic [15:0] im, input logic last);
    int t = 0;
    fft_re = re; fft_im = im; fft_last = last; fft_valid = 1'b1;
    @(negedge clk);
    while (!fft_ready && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1 fft_valid = 1'b0; fft_last = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || pgram_valid) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) check("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic frame(input int n, input int last_at);
    for (int i = 0; i < n; i++) beat(16'(i * 61), 16'(-(i * 37)), i == last_at);
  endtask

  initial begin
    clear_stats();
    #1;
    check("rst_ready", fft_ready, 1);
    check("rst_valid", pgram_valid, 0);
    check("rst_data", pgram_data, 0);
    check("rst_last", pgram_last, 0);
    check("rst_err", frame_err, 0);
    do_reset();

    // Single beat latency: accepted at E0, visible after E2, popped at E3.
    fft_re = 16'sh4000; fft_im = '0; fft_valid = 1'b1;
    @(posedge clk); #1 fft_valid = 1'b0;
    check("lat_e0_valid", pgram_valid, 0);
    @(posedge clk); #1 check("lat_e1_valid", pgram_valid, 0);
    @(posedge clk); #1 check("lat_e2_valid", pgram_valid, 1);
    check("lat_data", pgram_data, 8192);
    check("lat_last", pgram_last, 0);
    @(posedge clk); #1 check("lat_e3_valid", pgram_valid, 0);
    drain();

    do_reset();
    beat(16'h8000, 16'h8000, 1'b0);
    beat(16'hfffd, 16'h0004, 1'b0);
    drain();
    check("max_count", n_out, 2);
    check("max_data", out_q.size() > 0 ? out_q[0] : -1, 65536);
    check("small_data", out_q.size() > 1 ? out_q[1] : -1, 0);

    do_reset();
    frame(512, 511);
    drain();
    check("frame_outputs", n_out, 257);
    check("frame_nlast", n_last, 1);
    check("frame_lastpos", last_pos, 257);
    check("frame_err0", frame_err, 0);
    clear_stats();
    frame(257, -1);
    drain();
    check("next_frame_lastpos", last_pos, 257);

    // Back-pressure: exactly FIFO_DEPTH beats fit, then release and drain in order.
    do_reset();
    pgram_ready = 1'b0;
    fft_im = '0; fft_last = 1'b0; fft_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      fft_re = 16'(((n_acc + 1) * 1000));
      @(posedge clk); #1;
    end
    fft_valid = 1'b0;
    check("bp_accepted", n_acc, 8);
    check("bp_ready", fft_ready, 0);
    check("bp_hold_valid", pgram_valid, 1);
    check("bp_hold_data", pgram_data, 30);
    pgram_ready = 1'b1;
    drain();
    check("bp_outputs", n_out, 8);
    for (int k = 0; k < 8; k++) check($sformatf("bp_data%0d", k), out_q.size() > k ? out_q[k] : -1, bp_exp[k]);

    do_reset();
    frame(101, 100);
    check("early_last_err", frame_err, 1);
    drain();
    check("early_outputs", n_out, 101);
    check("early_nlast", n_last, 0);
    clear_stats();
    frame(257, -1);
    drain();
    check("resync_lastpos", last_pos, 257);
    check("err_sticky", frame_err, 1);

    // Asynchronous reset with five entries parked in the FIFO.
    do_reset();
    pgram_ready = 1'b0;
    frame(5, -1);
    repeat (4) @(posedge clk);
    check("pre_rst_valid", pgram_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", pgram_valid, 0);
    check("arst_ready", fft_ready, 1);
    check("arst_data", pgram_data, 0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    clear_stats();
    pgram_ready = 1'b1;
    frame(512, 511);
    drain();
    check("post_rst_outputs", n_out, 257);
    check("post_rst_lastpos", last_pos, 257);
    check("post_rst_err", frame_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/power_spectrum.md
# power_spectrum

Converts complex FFT bins into the periodogram stream consumed by the Mel filterbank. For each frame it accepts FFT_SIZE complex bins. It squares the magnitude of the first NUM_BINS bins (re² + im², rescaled to Q15) and discards the mirrored upper half. Results are buffered in a small FIFO and presented as a 32-bit signed sample stream with valid/ready and an end-of-frame marker. Inputs come from the FFT; the output feeds the Mel filterbank's data_in/data_valid.

## Interface
- IN_W, 16: width of fft_re/fft_im, signed Q15
- Q, 15: fractional bits; products are shifted right by Q
- FFT_SIZE, 512: bins per input frame (power of two)
- NUM_BINS, 257: bins forwarded per frame (FFT_SIZE/2+1), 1..FFT_SIZE
- FIFO_DEPTH, 8: output FIFO entries (power of two, >= 4)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- fft_re  in  IN_W  signed real part
- fft_im  in  IN_W  signed imaginary part
- fft_valid  in  1  input beat valid
- fft_last  in  1  marks last bin of the FFT frame
- fft_ready  out  1  block can accept a beat
- pgram_data  out  32  signed periodogram sample, Q15, always >= 0
- pgram_valid  out  1  pgram_data valid
- pgram_last  out  1  marks sample NUM_BINS-1 of a frame
- pgram_ready  in  1  downstream accepts the sample
- frame_err  out  1  sticky flag: fft_last received at the wrong bin index

## Operation
- Input beat is accepted when fft_valid && fft_ready at a rising edge.
- bin_idx counter (log2(FFT_SIZE) bits) increments on every accepted beat.
  - It wraps to 0 after FFT_SIZE-1.
  - It is forced to 0 after any accepted beat carrying fft_last.
- Accepted beats with bin_idx < NUM_BINS enter the pipeline. Others are consumed and dropped; no output is produced for them.
- Stage 1 registers rr = fft_re*fft_re and ii = fft_im*fft_im, each 2*IN_W bits unsigned. It also registers is_last = (bin_idx == NUM_BINS-1).
- Stage 2 registers p = (rr + ii) >> Q.
  - The sum is computed at 2*IN_W+1 bits, so there is no overflow.
  - The result is zero-extended to 32 bits. Truncation, no rounding.
  - Maximum value: re = im = -32768 gives 65536.
- Stage 2 output is pushed into the FIFO as {is_last, p}, 33 bits.
- FIFO is show-ahead: the head entry drives pgram_data/pgram_last; pgram_valid = !empty. An entry is popped when pgram_valid && pgram_ready.
- fft_ready = (fifo_count + stage1_valid + stage2_valid) < FIFO_DEPTH. This is a registered-free combinational function of current state and guarantees no push into a full FIFO.
  - Dropped bins are gated by the same rule.
- frame_err sets when fft_last is accepted with bin_idx != FFT_SIZE-1. It stays set until reset.
  - The counter still resynchronises to 0, so the next beat is bin 0.
- Push and pop in the same cycle leave fifo_count unchanged and are legal at any occupancy, including full.

## Timing
- Reset values: fft_ready=1, pgram_valid=0, pgram_data=0, pgram_last=0, frame_err=0. bin_idx, pipeline valids and fifo_count are all 0.
- Latency, FIFO empty and pgram_ready=1:
  - beat accepted at edge E0;
  - stage 1 valid after E0;
  - stage 2 valid after E1;
  - FIFO write at E2;
  - pgram_valid high in the cycle after E2.
  - Result: 3 edges from accept to visible output.
- Throughput: one bin per cycle while pgram_ready stays high.
- The pipeline never stalls internally. Back-pressure acts only through fft_ready, so in-flight entries always have a reserved slot.
- pgram_data/pgram_last are stable while pgram_valid=1 and pgram_ready=0.
- Reset asserted mid-frame:
  - all outputs return to reset values immediately (asynchronously);
  - FIFO and in-flight data are discarded;
  - bin_idx restarts at 0.

## Test plan
- Single beat, re=0x4000, im=0x0000 at bin 0 -> pgram_data=8192 three edges later, pgram_valid for 1 cycle, pgram_last=0.
- re=im=0x8000 (-32768) at bin 0 -> pgram_data=65536. re=-3, im=4 -> pgram_data=0 (25>>15).
- Full frame of 512 beats, fft_last on beat 511, ramp data, pgram_ready=1 -> exactly 257 outputs matching the model; pgram_last only on output 257; frame_err=0; the next frame restarts at bin 0.
- pgram_ready held 0, fft_valid=1 continuously -> exactly 8 beats accepted, then fft_ready=0. Release pgram_ready -> all 8 emitted in order with no loss or duplication.
- fft_last asserted on beat 100 of a frame -> frame_err=1 and stays 1. Beats 0..100 produce 101 outputs. The next beat is treated as bin 0.
- rst pulsed asynchronously mid-frame with 5 entries in the FIFO -> pgram_valid=0 and fft_ready=1 immediately. The next frame produces a clean 257-sample output.
